// File: rtl/sar_conv_scheduler.sv
// Round-robin conversion scheduler in front of a binary-search SAR controller.
// Latches per-channel requests, selects the mux, pulses go and reports each result with a channel tag.
module sar_conv_scheduler #(
    parameter int NOB     = 8,
    parameter int NCH     = 4,
    parameter int CHW     = 2,
    parameter int SETTLE  = 2,
    parameter int TIMEOUT = 20
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             en,
    input  logic [NCH-1:0]   req,
    output logic [CHW-1:0]   ch_sel,
    output logic             sar_go,
    input  logic             sar_valid,
    input  logic [NOB-1:0]   sar_result,
    output logic             res_valid,
    output logic [NOB-1:0]   res_data,
    output logic [CHW-1:0]   res_ch,
    output logic             res_err,
    output logic [NCH-1:0]   pending,
    output logic             busy,
    output logic [2:0]       dbg_state
);

    typedef enum logic [2:0] {
        S_IDLE   = 3'd0,
        S_SELECT = 3'd1,
        S_GO     = 3'd2,
        S_CLR    = 3'd3,
        S_WAIT   = 3'd4,
        S_DONE   = 3'd5
    } state_t;

    localparam int SW = (SETTLE > 1) ? $clog2(SETTLE) : 1;
    localparam int TW = $clog2(TIMEOUT);
    localparam logic [SW-1:0]  SETTLE_LAST = SW'(SETTLE - 1);
    localparam logic [TW-1:0]  TO_LAST     = TW'(TIMEOUT - 1);
    localparam logic [CHW-1:0] CH_LAST     = CHW'(NCH - 1);

    state_t         state, state_n;
    logic [CHW-1:0] ptr;
    logic [SW-1:0]  scnt;
    logic [TW-1:0]  tcnt;
    logic           grant_found, grant, capture, tmo;
    logic [CHW-1:0] grant_idx;
    logic [NCH-1:0] clr_vec;

    // Scanning upward from ptr with wrap gives "lowest >= ptr, else lowest overall".
    always_comb begin
        grant_found = 1'b0;
        grant_idx   = '0;
        for (int i = 0; i < NCH; i++) begin
            if (!grant_found && pending[(int'(ptr) + i) % NCH]) begin
                grant_found = 1'b1;
                grant_idx   = CHW'((int'(ptr) + i) % NCH);
            end
        end
    end

    // SAR handshake: sar_go is a one-cycle start; the SAR drops sar_valid on that
    // edge and later raises it as a level, so valid is only trusted from WAIT onward.
    always_comb begin
        state_n = state;
        grant   = 1'b0;
        capture = 1'b0;
        tmo     = 1'b0;
        unique case (state)
            S_IDLE: begin
                if (en && grant_found) begin
                    grant   = 1'b1;
                    state_n = S_SELECT;
                end
            end
            S_SELECT: if (scnt == '0) state_n = S_GO;
            S_GO:     state_n = S_CLR;
            S_CLR:    state_n = S_WAIT;
            S_WAIT: begin
                if (sar_valid) begin
                    capture = 1'b1;
                    state_n = S_DONE;
                end else if (tcnt == TO_LAST) begin
                    tmo     = 1'b1;
                    state_n = S_DONE;
                end
            end
            S_DONE:   state_n = S_IDLE;
            default:  state_n = S_IDLE;
        endcase
    end

    assign clr_vec = grant ? (NCH'(1) << grant_idx) : '0;

    always_ff @(posedge clk) begin
        if (rst) begin
            state    <= S_IDLE;
            pending  <= '0;
            ptr      <= '0;
            scnt     <= '0;
            tcnt     <= '0;
            ch_sel   <= '0;
            res_data <= '0;
            res_ch   <= '0;
            res_err  <= 1'b0;
        end else begin
            state   <= state_n;
            pending <= (pending & ~clr_vec) | req;
            if (grant) begin
                ch_sel <= grant_idx;
                ptr    <= (grant_idx == CH_LAST) ? '0 : grant_idx + 1'b1;
                scnt   <= SETTLE_LAST;
            end else if (state == S_SELECT && scnt != '0) begin
                scnt <= scnt - 1'b1;
            end
            if (state == S_CLR) begin
                tcnt <= '0;
            end else if (state == S_WAIT && !sar_valid && tcnt != TO_LAST) begin
                tcnt <= tcnt + 1'b1;
            end
            if (capture) begin
                res_data <= sar_result;
                res_ch   <= ch_sel;
                res_err  <= 1'b0;
            end else if (tmo) begin
                res_data <= '0;
                res_ch   <= ch_sel;
                res_err  <= 1'b1;
            end
        end
    end

    assign sar_go    = (state == S_GO);
    assign res_valid = (state == S_DONE);
    assign busy      = (state != S_IDLE);
    assign dbg_state = state;

endmodule

// File: doc/sar_conv_scheduler.md
Name: sar_conv_scheduler

Overview:
Multi-channel conversion scheduler for the binary-search SAR controller. Latches per-channel conversion requests and grants them round-robin. For each grant it drives the analog mux select, waits a settle time, then pulses go to the SAR controller and captures its result on valid. A timeout guards against a SAR that never converges, and every completion is reported with the channel tag and an error flag.

Parameters:
NOB, 8, SAR result width in bits
NCH, 4, number of input channels (2..16)
CHW, 2, channel index width, equal to clog2(NCH)
SETTLE, 2, mux settle cycles before go (>=1)
TIMEOUT, 20, maximum cycles spent in WAIT before abort (>=2)

Ports:
clk  in  1  clock, all logic on rising edge
rst  in  1  synchronous reset, active-high
en  in  1  scheduler enable; 0 blocks new grants, in-flight conversion still completes
req  in  NCH  per-channel request pulse; a 1 sets that channel's pending bit
ch_sel  out  CHW  analog mux select, registered
sar_go  out  1  one-cycle start pulse to the SAR controller, registered
sar_valid  in  1  SAR result-valid (level)
sar_result  in  NOB  SAR result
res_valid  out  1  one-cycle completion strobe
res_data  out  NOB  captured result; 0 on timeout
res_ch  out  CHW  channel of res_data
res_err  out  1  timeout flag, qualified by res_valid
pending  out  NCH  pending request bits
busy  out  1  high whenever the state is not IDLE

Behaviour:
- Reset, sampled on a clk edge with rst=1:
  - state=IDLE, pending=0, rr pointer=0, counters=0.
  - ch_sel=0, sar_go=0, res_valid=0, res_data=0, res_ch=0, res_err=0, busy=0.
  - Reset mid-conversion aborts immediately, and the result is never reported.
- pending[i] update each cycle: next = (pending[i] & ~clr[i]) | req[i].
  - clr[i] is asserted in the grant cycle for the granted channel.
  - If req[i] and clr[i] are high in the same cycle, the set wins and the channel is re-queued.
- Arbitration in IDLE, when en=1 and pending!=0:
  - Grant the lowest index >= ptr that is pending; if none, wrap to the lowest pending index overall.
  - On grant: ch_sel<=granted index, ptr<=granted+1 mod NCH, settle counter<=SETTLE-1, go to SELECT.
  - Fairness: with all channels pending, grants run 0,1,..,NCH-1,0,...
- SELECT: decrement the settle counter; when it reads 0, go to GO. ch_sel is stable for exactly SETTLE cycles before GO.
- GO: sar_go=1 for this single cycle; go to CLR.
- CLR: sar_valid is ignored, because the SAR clears valid on the go edge and the stale high level must not be captured. Timeout counter<=0; go to WAIT.
- WAIT, checked each cycle:
  - If sar_valid=1: capture res_data<=sar_result, res_ch<=ch_sel, res_err<=0; go to DONE.
  - Else if the timeout counter equals TIMEOUT-1: res_data<=0, res_ch<=ch_sel, res_err<=1; go to DONE.
  - Otherwise increment the timeout counter.
  - sar_valid has priority when it coincides with the timeout cycle.
- DONE: res_valid=1 for one cycle; go to IDLE.
  - res_data, res_ch and res_err hold their values until the next DONE.
  - A new grant is possible in the first IDLE cycle after DONE, so there is a minimum of 1 idle cycle between conversions.
- Latency, grant edge to res_valid (SAR valid seen on the k-th WAIT cycle, k>=1): SETTLE + 2 + k cycles.
- en=0 while busy has no effect until the state returns to IDLE. Requests arriving while en=0 still accumulate in pending.
- ch_sel holds its last value in IDLE. sar_go is never high outside GO.

Test Plan:
- Single request: req=0010 pulse, SAR model returns 0xA5 valid 8 cycles after go -> ch_sel=1 for 2 cycles before sar_go, one sar_go pulse, res_valid with res_data=0xA5, res_ch=1, res_err=0, pending=0000 afterward.
- Round-robin: req=1111 in one cycle -> grants in the order 0,1,2,3. Then req=1001 after ptr=0 -> order 0,3. Exactly one res_valid per grant.
- Stale valid: hold sar_valid=1 high through GO, then drop it low in CLR and raise it 5 cycles later with 0x3C -> capture 0x3C, not the stale value.
- Timeout: SAR never asserts valid -> res_valid exactly TIMEOUT+1 cycles after the CLR cycle, with res_err=1, res_data=0x00. The next pending channel is then served.
- Re-request collision: req[2] pulsed in the same cycle channel 2 is granted -> channel 2 converts twice, with res_ch=2 reported twice.
- Enable and reset: en=0 with req=0100 -> no sar_go, pending=0100; then en=1 -> conversion starts. Assert rst during WAIT -> next cycle busy=0, pending=0, no res_valid issued.
